spi_ram_arbiter: RTL and testbench

Shares the single external SPI RAM between nanoV's instruction-fetch port and data load/store port. It arbitrates round-robin between the two requesters and runs a complete SPI RAM transaction per grant: chip select, 8-bit command, 24-bit address, then 1/2/4 data bytes. Its SPI pins map directly onto the top-level `uio_out[0..2]` / `uio_in[3]` SPI RAM pins.

---
 rtl/nanov_spi_pkg.sv | 49 ++++
 rtl/spi_ram_arbiter_shifter.sv | 45 ++++
 rtl/spi_ram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_spi_pkg.sv
// Shared types and helpers for the nanoV SPI RAM arbiter.
// Holds the transaction states, default opcodes and transfer-size encodings.
package nanov_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_e;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_WALT = 2'd3;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // The first byte on the wire lands in the highest received lane.
    function automatic logic [31:0] place_lanes(
        input logic [31:0] rx,
        input logic [1:0]  size
    );
        logic [31:0] r;
        case (size_bytes(size))
            3'd1:    r = {24'h0, rx[7:0]};
            3'd2:    r = {16'h0, rx[7:0], rx[15:8]};
            default: r = bswap32(rx);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_shifter.sv
// SPI mode-0 bit engine: 32-bit MSB-first transmit register, phase toggle
// and receive register sampled at the end of the high phase.
module spi_bit_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        shift_en_i,
    input  logic        miso_i,
    output logic        mosi_o,
    output logic        sclk_o,
    output logic [31:0] rx_o
);

    logic [31:0] sr_q;
    logic [30:0] rx_q;
    logic        phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            rx_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            if (shift_en_i && phase_q) begin
                rx_q <= {rx_q[29:0], miso_i};
            end
            if (load_i) begin
                sr_q    <= load_data_i;
                phase_q <= 1'b0;
            end else if (shift_en_i) begin
                phase_q <= ~phase_q;
                if (phase_q) begin
                    sr_q <= {sr_q[30:0], 1'b0};
                end
            end
        end
    end

    assign mosi_o = sr_q[31];
    assign sclk_o = phase_q;
    // Includes the bit being sampled on this edge.
    assign rx_o   = {rx_q, miso_i};

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one SPI RAM between nanoV fetch and data ports.
// Each grant runs a full CMD/ADDR/DATA transaction, then acks for one cycle.
module spi_ram_arbiter
    import nanov_spi_pkg::*;
#(
    parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [23:0] f_addr,
    output logic        f_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [23:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        spi_select,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    state_e      state_q;
    logic        last_q;
    logic        port_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [23:0] addr_q;
    logic [31:0] wdata_q;
    logic [5:0]  cnt_q;
    logic        sel_q;
    logic        f_ack_q;
    logic        d_ack_q;
    logic [31:0] rdata_q;

    logic        grant_f;
    logic        grant_d;
    logic        last_bit;
    logic        ld;
    logic [31:0] ld_data;
    logic        shift_en;
    logic        sclk_w;
    logic        mosi_w;
    logic [31:0] rx_w;

    // last_q = 1 means data was granted last, so a tie goes to fetch.
    always_comb begin
        grant_f  = f_req && (!d_req || last_q);
        grant_d  = d_req && !grant_f;
        last_bit = sclk_w && (cnt_q == 6'd1);
        shift_en = (state_q == CMD) || (state_q == ADDR) ||
                   (state_q == DATA);
        ld       = 1'b0;
        ld_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_f || grant_d) begin
                    ld      = 1'b1;
                    ld_data = {(grant_d && d_we) ? CMD_WRITE : CMD_READ,
                               24'h0};
                end
            end
            CMD: begin
                if (last_bit) begin
                    ld      = 1'b1;
                    ld_data = {addr_q, 8'h00};
                end
            end
            ADDR: begin
                if (last_bit) begin
                    ld      = 1'b1;
                    ld_data = we_q ? bswap32(wdata_q) : '0;
                end
            end
            DATA: begin
                ld = last_bit;
            end
            default: begin
                ld = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b1;
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            if (sclk_w) begin
                cnt_q <= cnt_q - 6'd1;
            end
            unique case (state_q)
                IDLE: begin
                    if (grant_f || grant_d) begin
                        state_q <= CMD;
                        sel_q   <= 1'b0;
                        cnt_q   <= 6'd8;
                        rdata_q <= '0;
                        last_q  <= grant_d;
                        port_q  <= grant_d;
                        we_q    <= grant_d && d_we;
                        size_q  <= grant_d ? d_size : SZ_WORD;
                        addr_q  <= grant_d ? d_addr : f_addr;
                        wdata_q <= d_wdata;
                    end
                end
                CMD: begin
                    if (last_bit) begin
                        state_q <= ADDR;
                        cnt_q   <= 6'd24;
                    end
                end
                ADDR: begin
                    if (last_bit) begin
                        state_q <= DATA;
                        cnt_q   <= {size_bytes(size_q), 3'b000};
                    end
                end
                DATA: begin
                    if (last_bit) begin
                        state_q <= DONE;
                        sel_q   <= 1'b1;
                        f_ack_q <= ~port_q;
                        d_ack_q <= port_q;
                        if (!we_q) begin
                            rdata_q <= place_lanes(rx_w, size_q);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    spi_bit_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (ld),
        .load_data_i (ld_data),
        .shift_en_i  (shift_en),
        .miso_i      (spi_miso),
        .mosi_o      (mosi_w),
        .sclk_o      (sclk_w),
        .rx_o        (rx_w)
    );

    assign f_ack      = f_ack_q;
    assign d_ack      = d_ack_q;
    assign rdata      = rdata_q;
    assign busy       = (state_q != IDLE);
    assign spi_select = sel_q;
    assign spi_clk    = sclk_w;
    assign spi_mosi   = mosi_w;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural SPI RAM model.
// Checks latency, wire bytes, read data, arbitration order and reset abort.
module tb_spi_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        f_req = 1'b0;
    logic [23:0] f_addr = '0;
    logic        f_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic [23:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] rdata;
    logic        busy;
    logic        spi_select;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0;
    int ta;

    logic [7:0]  mem [0:4095];
    int          m_bits;
    int          m_rise;
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic [63:0] m_tx;
    logic [7:0]  m_wb;

    spi_ram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_ack      (f_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .rdata      (rdata),
        .busy       (busy),
        .spi_select (spi_select),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI RAM: samples MOSI on rising SCLK, presents MISO for the high phase.
    initial begin : ram_model
        int       idx;
        int       bp;
        logic [11:0] a;
        logic [7:0]  byte_v;
        logic        b;
        spi_miso = 1'b0;
        m_bits = 0;
        m_rise = 0;
        m_cmd = '0;
        m_addr = '0;
        m_tx = '0;
        m_wb = '0;
        forever begin
            @(posedge spi_clk or negedge spi_select);
            if (spi_select === 1'b0) begin
                if (spi_clk !== 1'b1) begin
                    m_bits = 0;
                    m_rise = 0;
                    m_tx = '0;
                    spi_miso = 1'b0;
                end else begin
                    b = spi_mosi;
                    m_tx = {m_tx[62:0], b};
                    m_rise++;
                    if (m_bits < 8) begin
                        m_cmd = {m_cmd[6:0], b};
                    end else if (m_bits < 32) begin
                        m_addr = {m_addr[22:0], b};
                    end else begin
                        idx = (m_bits - 32) / 8;
                        bp = 7 - ((m_bits - 32) % 8);
                        a = m_addr[11:0] + 12'(idx);
                        if (m_cmd == 8'h02) begin
                            m_wb = {m_wb[6:0], b};
                            if (bp == 0) mem[a] = m_wb;
                        end else begin
                            byte_v = mem[a];
                            spi_miso = byte_v[bp];
                        end
                    end
                    m_bits++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input string tag, input logic want_d,
                            input int from, input int lat);
        int k;
        k = 0;
        while (k < 300 && !(f_ack || d_ack)) begin
            step(1);
            k++;
        end
        chk({tag, "_lat"}, 64'(cyc - from), 64'(lat));
        chk({tag, "_dack"}, 64'(d_ack), 64'(want_d));
        chk({tag, "_fack"}, 64'(f_ack), 64'(!want_d));
        chk({tag, "_sel"}, 64'(spi_select), 64'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic want;
        int   lat;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h13;
        mem[12'h101] = 8'h05;

        #1 rst_n = 1'b0;
        step(2);
        chk("rst_sel", 64'(spi_select), 64'd1);
        chk("rst_sclk", 64'(spi_clk), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_fack", 64'(f_ack), 64'd0);
        chk("rst_dack", 64'(d_ack), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step(2);

        f_addr = 24'h000100;
        f_req = 1'b1;
        t0 = cyc;
        step(1);
        chk("fetch_selfall", 64'(spi_select), 64'd0);
        chk("fetch_busy", 64'(busy), 64'd1);
        wait_ack("fetch", 1'b0, t0, 129);
        f_req = 1'b0;
        chk("fetch_rdata", 64'(rdata), 64'h0000_0513);
        chk("fetch_tx", m_tx, 64'h0300_0100_0000_0000);
        chk("fetch_rises", 64'(m_rise), 64'd64);
        step(2);

        d_we = 1'b1;
        d_size = 2'd0;
        d_addr = 24'h000010;
        d_wdata = 32'hDEAD_BEA5;
        d_req = 1'b1;
        t0 = cyc;
        wait_ack("wr1", 1'b1, t0, 81);
        d_req = 1'b0;
        chk("wr1_tx", 64'(m_tx[39:0]), 64'h02_0000_10A5);
        chk("wr1_rises", 64'(m_rise), 64'd40);
        chk("wr1_mem", 64'(mem[12'h010]), 64'hA5);
        chk("wr1_mem_next", 64'(mem[12'h011]), 64'h00);
        chk("wr1_rdata", 64'(rdata), 64'd0);
        step(2);

        d_we = 1'b0;
        d_size = 2'd1;
        d_addr = 24'h000100;
        d_req = 1'b1;
        t0 = cyc;
        wait_ack("rd2", 1'b1, t0, 97);
        d_req = 1'b0;
        chk("rd2_rdata", 64'(rdata), 64'h0000_0513);
        chk("rd2_hi", 64'(rdata[31:16]), 64'd0);
        chk("rd2_tx", 64'(m_tx[47:0]), 64'h03_0001_00_0000);
        step(2);

        d_we = 1'b1;
        d_size = 2'd3;
        d_addr = 24'h000200;
        d_wdata = 32'h4433_2211;
        d_req = 1'b1;
        t0 = cyc;
        wait_ack("wr4", 1'b1, t0, 129);
        d_req = 1'b0;
        chk("wr4_tx", m_tx, 64'h0200_0200_1122_3344);
        chk("wr4_mem", 64'({mem[12'h203], mem[12'h202],
                            mem[12'h201], mem[12'h200]}),
            64'h4433_2211);
        step(3);

        d_we = 1'b0;
        d_size = 2'd0;
        d_addr = 24'h000010;
        d_req = 1'b1;
        t0 = cyc;
        wait_ack("rd1", 1'b1, t0, 81);
        d_req = 1'b0;
        chk("rd1_rdata", 64'(rdata), 64'h0000_00A5);
        step(2);

        f_addr = 24'h000100;
        f_req = 1'b1;
        d_we = 1'b0;
        d_size = 2'd1;
        d_addr = 24'h000100;
        d_req = 1'b1;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2) == 1;
            lat = (i == 0) ? 129 : (want ? 98 : 130);
            wait_ack($sformatf("tie%0d", i), want, t0, lat);
            ta = cyc;
            if (i == 3) begin
                f_req = 1'b0;
                d_req = 1'b0;
            end
            step(1);
            chk($sformatf("tie%0d_gap", i), 64'(spi_select), 64'd1);
            t0 = ta;
        end
        step(2);

        f_addr = 24'h000100;
        f_req = 1'b1;
        t0 = cyc;
        step(30);
        chk("abort_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_sel", 64'(spi_select), 64'd1);
        chk("abort_sclk", 64'(spi_clk), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("abort_noack%0d", i), 64'(f_ack), 64'd0);
        end
        rst_n = 1'b1;
        t0 = cyc;
        wait_ack("rerun", 1'b0, t0, 129);
        f_req = 1'b0;
        chk("rerun_rdata", 64'(rdata), 64'h0000_0513);
        chk("rerun_tx", m_tx, 64'h0300_0100_0000_0000);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
